csr_amm_arbiter: RTL and testbench

CSR_AMM_ARBITER -- requirements
Module: csr_amm_arbiter

---
 rtl/csr_amm_arbiter.sv | 173 +++++++++++++++++
 tb/tb_csr_amm_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_amm_arbiter.sv
// rtl/csr_amm_arbiter.sv - two-requester round-robin arbiter onto one CSR Avalon-MM bridge
// Optional read watchdog: define CSR_ARB_TIMEOUT_EN to enable it (TIMEOUT_CYC sets the limit).
module csr_amm_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    // requester 0
    input  logic [ADDR_W-1:0]   s0_address,
    input  logic                s0_read,
    input  logic                s0_write,
    input  logic [DATA_W-1:0]   s0_writedata,
    input  logic [DATA_W/8-1:0] s0_byteenable,
    output logic                s0_waitrequest,
    output logic [DATA_W-1:0]   s0_readdata,
    output logic                s0_readdatavalid,
    // requester 1
    input  logic [ADDR_W-1:0]   s1_address,
    input  logic                s1_read,
    input  logic                s1_write,
    input  logic [DATA_W-1:0]   s1_writedata,
    input  logic [DATA_W/8-1:0] s1_byteenable,
    output logic                s1_waitrequest,
    output logic [DATA_W-1:0]   s1_readdata,
    output logic                s1_readdatavalid,
    // CSR bridge
    output logic [ADDR_W-1:0]   m_address,
    output logic                m_read,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    output logic [DATA_W/8-1:0] m_byteenable,
    output logic                m_burstcount,
    input  logic                m_waitrequest,
    input  logic [DATA_W-1:0]   m_readdata,
    input  logic                m_readdatavalid,
    output logic                timeout_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                grant_q, grant_d;           // 0 = s0, 1 = s1
    logic                last_grant_q, last_grant_d;
    logic                req0, req1;
    logic [ADDR_W-1:0]   g_address;
    logic                g_read, g_write;
    logic [DATA_W-1:0]   g_writedata;
    logic [DATA_W/8-1:0] g_byteenable;
    logic                expire;
    logic                rsp_valid;
    logic [DATA_W-1:0]   rsp_data;

    assign req0 = s0_read | s0_write;
    assign req1 = s1_read | s1_write;

    // Select the command fields of whichever requester currently holds the grant
    always_comb begin
        g_address    = grant_q ? s1_address    : s0_address;
        g_read       = grant_q ? s1_read       : s0_read;
        g_write      = grant_q ? s1_write      : s0_write;
        g_writedata  = grant_q ? s1_writedata  : s0_writedata;
        g_byteenable = grant_q ? s1_byteenable : s0_byteenable;
    end

`ifdef CSR_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int REP   = (DATA_W + 31) / 32;
    localparam logic [REP*32-1:0] TO_REP = {REP{32'hDEADBEEF}};

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    assign expire    = (state_q == RD_WAIT) && !m_readdatavalid &&
                       (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign rsp_data  = m_readdatavalid ? m_readdata : TO_REP[DATA_W-1:0];
    assign timeout_o = timeout_q;

    // Watchdog counts cycles spent in RD_WAIT; the flag stays set until reset
    always_comb begin
        cnt_d     = '0;
        timeout_d = timeout_q | expire;
        if ((state_q == RD_WAIT) && (state_d == RD_WAIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Watchdog registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
`else
    assign expire    = 1'b0;
    assign rsp_data  = m_readdata;
    assign timeout_o = 1'b0;
`endif

    // Next-state: grant in IDLE, issue in CMD, collect the read response in RD_WAIT
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // on a tie the port that was not served last wins
                    grant_d      = (req0 && req1) ? ~last_grant_q : req1;
                    last_grant_d = grant_d;
                    state_d      = CMD;
                end
            end
            CMD: begin
                if (!g_read && !g_write) begin
                    state_d = IDLE;
                end else if (!m_waitrequest) begin
                    state_d = g_read ? RD_WAIT : IDLE;
                end
            end
            RD_WAIT: begin
                if (m_readdatavalid || expire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, grant and round-robin history registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Bridge command: live mirror of the granted port, read wins over write
    always_comb begin
        m_address    = g_address;
        m_writedata  = g_writedata;
        m_byteenable = g_byteenable;
        m_burstcount = 1'b1;
        m_read       = (state_q == CMD) && g_read;
        m_write      = (state_q == CMD) && g_write && !g_read;
    end

    // Requester responses: stalls follow the bridge only for the granted port in CMD
    always_comb begin
        rsp_valid        = (state_q == RD_WAIT) && (m_readdatavalid || expire);
        s0_waitrequest   = ((state_q == CMD) && !grant_q) ? m_waitrequest : 1'b1;
        s1_waitrequest   = ((state_q == CMD) &&  grant_q) ? m_waitrequest : 1'b1;
        s0_readdatavalid = rsp_valid && !grant_q;
        s1_readdatavalid = rsp_valid &&  grant_q;
        s0_readdata      = s0_readdatavalid ? rsp_data : '0;
        s1_readdata      = s1_readdatavalid ? rsp_data : '0;
    end

endmodule

// File: tb/tb_csr_amm_arbiter.sv
// tb/tb_csr_amm_arbiter.sv - directed self-checking bench for csr_amm_arbiter
module tb_csr_amm_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [15:0] s0_address, s1_address, m_address;
    logic        s0_read, s0_write, s1_read, s1_write;
    logic [31:0] s0_writedata, s1_writedata, m_writedata;
    logic [3:0]  s0_byteenable, s1_byteenable, m_byteenable;
    logic        s0_waitrequest, s1_waitrequest;
    logic [31:0] s0_readdata, s1_readdata, m_readdata;
    logic        s0_readdatavalid, s1_readdatavalid;
    logic        m_read, m_write, m_burstcount;
    logic        m_waitrequest, m_readdatavalid;
    logic        timeout_o;

    int checks = 0;
    int failures = 0;

    logic [31:0] rr_tab [4] = '{32'h000000A0, 32'h000000B1, 32'h000000A2, 32'h000000B3};
    logic [15:0] rr_addr [2] = '{16'h0100, 16'h0200};

    csr_amm_arbiter #(.ADDR_W(16), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write),
        .s0_writedata(s0_writedata), .s0_byteenable(s0_byteenable),
        .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata),
        .s0_readdatavalid(s0_readdatavalid),
        .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write),
        .s1_writedata(s1_writedata), .s1_byteenable(s1_byteenable),
        .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata),
        .s1_readdatavalid(s1_readdatavalid),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_burstcount(m_burstcount), .m_waitrequest(m_waitrequest),
        .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_edge();
        @(posedge clk_i);
        #1;
    endtask

    // s0 write; bridge stalls the first 'stall' CMD cycles
    task automatic do_write(input string tag, input logic [15:0] a, input logic [31:0] d,
                            input int stall);
        int beats = 0;
        int wlow = 0;
        int stalled = 0;
        int s1bad = 0;
        logic acc;
        logic [15:0] waddr = '0;
        logic [31:0] wdata = '0;
        s0_address    = a;
        s0_writedata  = d;
        s0_byteenable = 4'hF;
        s0_write      = 1'b1;
        m_waitrequest = (stall > 0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            acc = s0_write && !s0_waitrequest;
            if (m_write) begin
                if (m_waitrequest) stalled++;
                else begin
                    beats++;
                    waddr = m_address;
                    wdata = m_writedata;
                end
            end
            if (!s0_waitrequest) wlow++;
            if (!s1_waitrequest || s1_readdatavalid || m_read) s1bad++;
            drive_edge();
            if (acc) s0_write = 1'b0;
            if (stalled >= stall) m_waitrequest = 1'b0;
        end
        chk({tag, "_beats"}, beats, 1);
        chk({tag, "_wait_low"}, wlow, 1);
        chk({tag, "_stalled"}, stalled, stall);
        chk({tag, "_addr"}, waddr, a);
        chk({tag, "_data"}, wdata, d);
        chk({tag, "_s1_untouched"}, s1bad, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int k, nresp, lat, rdv_cyc, s0low_cyc, to_cyc;
        logic pend, acc0, acc1;
        logic [31:0] to_data;

        rst_n_i = 1'b0;
        s0_address = '0; s1_address = '0;
        s0_read = 0; s0_write = 0; s1_read = 0; s1_write = 0;
        s0_writedata = '0; s1_writedata = '0;
        s0_byteenable = 4'hF; s1_byteenable = 4'hF;
        m_waitrequest = 0; m_readdatavalid = 0; m_readdata = '0;

        // reset values
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_s0_wait", s0_waitrequest, 1);
        chk("rst_s1_wait", s1_waitrequest, 1);
        chk("rst_m_read", m_read, 0);
        chk("rst_m_write", m_write, 0);
        chk("rst_rdv", {s1_readdatavalid, s0_readdatavalid}, 0);
        chk("rst_rdata", {s1_readdata, s0_readdata}, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("burstcount", m_burstcount, 1);
        drive_edge();
        rst_n_i = 1'b1;

        // single write, no stall, then one stalled two cycles
        drive_edge();
        do_write("wr", 16'h0010, 32'h12345678, 0);
        do_write("wr_stall", 16'h0014, 32'hCAFEF00D, 2);

        // both ports reading continuously from reset: strict alternation
        drive_edge();
        rst_n_i = 1'b0;
        s0_address = rr_addr[0]; s1_address = rr_addr[1];
        s0_read = 1; s1_read = 1;
        drive_edge();
        rst_n_i = 1'b1;
        k = 0; nresp = 0; pend = 0;
        for (int c = 0; c < 40 && nresp < 4; c++) begin
            @(negedge clk_i);
            if (m_read && !m_waitrequest) begin
                chk($sformatf("rr_grant%0d", k), m_address, rr_addr[k % 2]);
                pend = 1;
            end
            if (s0_readdatavalid || s1_readdatavalid) begin
                chk($sformatf("rr_port%0d", nresp), {s1_readdatavalid, s0_readdatavalid},
                    (nresp % 2) ? 2'b10 : 2'b01);
                chk($sformatf("rr_data%0d", nresp),
                    s0_readdatavalid ? s0_readdata : s1_readdata, rr_tab[nresp]);
                nresp++;
            end
            drive_edge();
            m_readdatavalid = pend;
            m_readdata = pend ? rr_tab[k] : '0;
            if (pend) k++;
            pend = 0;
            if (nresp == 4) begin s0_read = 0; s1_read = 0; end
        end
        chk("rr_count", nresp, 4);
        m_readdatavalid = 0;

        // s1 read with 5-cycle latency; s0 write waits behind it
        drive_edge();
        s1_read = 1; s1_address = 16'h0300;
        lat = 0; rdv_cyc = -1; s0low_cyc = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_i);
            acc1 = s1_read && !s1_waitrequest;
            acc0 = s0_write && !s0_waitrequest;
            if (acc1) lat = 5;
            if (s1_readdatavalid) begin
                rdv_cyc = c;
                chk("lat_data", s1_readdata, 32'h000000C5);
            end
            if (!s0_waitrequest && s0low_cyc < 0) s0low_cyc = c;
            drive_edge();
            if (c == 0) begin
                s0_write = 1; s0_address = 16'h0040; s0_writedata = 32'h0BADF00D;
            end
            if (acc1) s1_read = 0;
            if (acc0) s0_write = 0;
            m_readdatavalid = 0;
            if (lat > 0) begin
                lat--;
                if (lat == 0) begin m_readdatavalid = 1; m_readdata = 32'h000000C5; end
            end
        end
        chk("lat_rdv_cycle", rdv_cyc, 6);
        chk("lat_s0_stalled_until", s0low_cyc, 8);

        // read+write together on s1 is a read
        drive_edge();
        s1_read = 1; s1_write = 1; s1_address = 16'h0050;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rw_m_read", m_read, 1);
        chk("rw_m_write", m_write, 0);
        chk("rw_addr", m_address, 16'h0050);
        drive_edge();
        s1_read = 0; s1_write = 0;
        m_readdatavalid = 1; m_readdata = 32'h000000E7;
        @(negedge clk_i);
        chk("rw_rdv", {s1_readdatavalid, s0_readdatavalid}, 2'b10);
        chk("rw_data", s1_readdata, 32'h000000E7);
        drive_edge();
        m_readdatavalid = 0;

        // reset while in RD_WAIT
        s0_read = 1; s0_address = 16'h0060;
        @(negedge clk_i);
        @(negedge clk_i);
        drive_edge();
        s0_read = 0;
        @(negedge clk_i);
        #2;
        rst_n_i = 0;
        m_readdatavalid = 1; m_readdata = 32'h000055AA;
        #1;
        chk("mid_rst_rdv", {s1_readdatavalid, s0_readdatavalid}, 0);
        chk("mid_rst_rdata", {s1_readdata, s0_readdata}, 0);
        chk("mid_rst_mcmd", {m_read, m_write}, 0);
        chk("mid_rst_wait", {s1_waitrequest, s0_waitrequest}, 2'b11);
        chk("mid_rst_timeout", timeout_o, 0);
        drive_edge();
        rst_n_i = 1;
        @(negedge clk_i);
        chk("stray_rdv", {s1_readdatavalid, s0_readdatavalid}, 0);
        drive_edge();
        m_readdatavalid = 0;

        // first tie after reset goes to s0, then s1
        s0_write = 1; s1_write = 1; s0_address = 16'h0070; s1_address = 16'h0080;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("tie_first", {m_write, m_address}, {1'b1, 16'h0070});
        drive_edge();
        s0_write = 0;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("tie_second", {m_write, m_address}, {1'b1, 16'h0080});
        drive_edge();
        s1_write = 0;

        // read that the bridge never answers
        s0_read = 1; s0_address = 16'h0090;
        @(negedge clk_i);
        @(negedge clk_i);
        drive_edge();
        s0_read = 0;
        to_cyc = 0; to_data = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk_i);
            if (s0_readdatavalid && to_cyc == 0) begin
                to_cyc = i;
                to_data = s0_readdata;
            end
            drive_edge();
        end
`ifdef CSR_ARB_TIMEOUT_EN
        chk("to_cycle", to_cyc, 8);
        chk("to_data", to_data, 32'hDEADBEEF);
        chk("to_flag", timeout_o, 1);
        s1_read = 1; s1_address = 16'h00A0;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("to_next_grant", {m_read, m_address}, {1'b1, 16'h00A0});
        drive_edge();
        s1_read = 0;
        m_readdatavalid = 1; m_readdata = 32'h00000077;
        @(negedge clk_i);
        chk("to_next_data", {s1_readdatavalid, s1_readdata}, {1'b1, 32'h00000077});
        chk("to_flag_sticky", timeout_o, 1);
        drive_edge();
        m_readdatavalid = 0;
`else
        chk("no_to_rdv", to_cyc, 0);
        chk("no_to_flag", timeout_o, 0);
        chk("no_to_stuck", s1_waitrequest, 1);
        rst_n_i = 0;
        drive_edge();
        rst_n_i = 1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
